// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types and constants for the Ascon data sequencer
package ascon_pkg;

  localparam int NUM_PT_BLOCKS_DEF = 3;
  localparam int MSG_WORDS         = NUM_PT_BLOCKS_DEF + 2;

  typedef enum logic [1:0] {
    PH_AD    = 2'd0,
    PH_PT    = 2'd1,
    PH_FINAL = 2'd2,
    PH_NONE  = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sequencer_state_e;

  // Message phase of the word at position pop_cnt: AD first, then the
  // plaintext blocks, then the single finalization block.
  function automatic phase_e phase_of(input logic [2:0] pop_cnt,
                                      input logic [2:0] pt_last);
    phase_e ph;
    if (pop_cnt == 3'd0)
      ph = PH_AD;
    else if (pop_cnt <= pt_last)
      ph = PH_PT;
    else if (pop_cnt == pt_last + 3'd1)
      ph = PH_FINAL;
    else
      ph = PH_NONE;
    return ph;
  endfunction

endpackage

// File: rtl/ascon_fifo2.sv
// rtl/ascon_fifo2.sv - two-entry register FIFO, head always from a register
module ascon_fifo2 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [1:0]            o_count,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] r_mem0;
  logic [DATA_WIDTH-1:0] r_mem1;
  logic [1:0]            r_count;
  logic                  w_pop_ok;
  logic                  w_push_ok;

  // A pop needs a word; a push needs a free slot before this edge, so a
  // full FIFO never takes a word even when it is popped in the same cycle.
  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && (r_count != 2'd2);

  // Storage and occupancy; entry 0 is the head, entry 1 the tail.
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10: begin
          if (r_count == 2'd0) r_mem0 <= i_data;
          else                 r_mem1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Only reachable at count 1: the new word replaces the head.
          r_mem0 <= i_data;
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem0;

endmodule

// File: rtl/ascon_data_sequencer.sv
// rtl/ascon_data_sequencer.sv - buffers host message words and feeds them to the Ascon FSM
module ascon_data_sequencer
  import ascon_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_PT_BLOCKS = MSG_WORDS - 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_sys_enable,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_consumed,
  input  logic                  i_done,
  output logic [1:0]            o_phase,
  output logic                  o_busy,
  output logic                  o_error
);

  localparam logic [2:0] MSG_LEN = 3'(NUM_PT_BLOCKS + 2);
  localparam logic [2:0] PT_LAST = 3'(NUM_PT_BLOCKS);

  sequencer_state_e r_state;
  logic [2:0]       r_acc_cnt;
  logic [2:0]       r_pop_cnt;
  logic             r_error;

  logic [1:0]       w_count;
  logic             w_run;
  logic             w_push;
  logic             w_pop;
  phase_e           w_phase;

  // Handshakes are decoded from registered state only, so neither host
  // valid nor the consume pulse reaches any output combinationally.
  assign w_run        = (r_state == ST_RUN);
  assign o_s_ready    = w_run && (w_count != 2'd2) && (r_acc_cnt < MSG_LEN);
  assign o_data_valid = w_run && (w_count != 2'd0);
  assign w_push       = i_s_valid && o_s_ready;
  assign w_pop        = i_data_consumed && o_data_valid;
  assign w_phase      = o_data_valid ? phase_of(r_pop_cnt, PT_LAST) : PH_NONE;
  assign o_phase      = w_phase;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_error      = r_error;

  ascon_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_flush (!i_sys_enable),
    .i_push  (w_push),
    .i_data  (i_s_data),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_head  (o_data)
  );

  // Message FSM with accept/retire counters and the sticky protocol error.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_acc_cnt <= 3'd0;
      r_pop_cnt <= 3'd0;
      r_error   <= 1'b0;
    end else if (!i_sys_enable) begin
      r_state   <= ST_IDLE;
      r_acc_cnt <= 3'd0;
      r_pop_cnt <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state   <= ST_RUN;
            r_acc_cnt <= 3'd0;
            r_pop_cnt <= 3'd0;
            r_error   <= 1'b0;
          end
          if (i_data_consumed) r_error <= 1'b1;
        end
        ST_RUN: begin
          if (w_push) r_acc_cnt <= r_acc_cnt + 3'd1;
          if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + 3'd1;
            if (r_pop_cnt == MSG_LEN - 3'd1) r_state <= ST_WAIT_DONE;
          end
          if ((i_data_consumed && !o_data_valid) || i_done) r_error <= 1'b1;
        end
        ST_WAIT_DONE: begin
          if (i_data_consumed) r_error <= 1'b1;
          if (i_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_data_sequencer.sv
// tb/tb_ascon_data_sequencer.sv - self-checking bench for ascon_data_sequencer
module tb_ascon_data_sequencer;

  localparam int DW  = 64;
  localparam int NPT = 3;
  localparam int MSG = NPT + 2;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_sys_enable = 1'b1;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_s_data = '0;
  logic          i_s_valid = 1'b0;
  logic          o_s_ready;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          i_data_consumed = 1'b0;
  logic          i_done = 1'b0;
  logic [1:0]    o_phase;
  logic          o_busy;
  logic          o_error;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  ascon_data_sequencer #(.DATA_WIDTH(DW), .NUM_PT_BLOCKS(NPT)) dut (
    .clock           (clock),
    .reset           (reset),
    .i_sys_enable    (i_sys_enable),
    .i_start         (i_start),
    .i_s_data        (i_s_data),
    .i_s_valid       (i_s_valid),
    .o_s_ready       (o_s_ready),
    .o_data          (o_data),
    .o_data_valid    (o_data_valid),
    .i_data_consumed (i_data_consumed),
    .i_done          (i_done),
    .o_phase         (o_phase),
    .o_busy          (o_busy),
    .o_error         (o_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Behavioural model: message as a queue of words plus progress counts.
  int          m_mode = M_IDLE;
  logic [DW-1:0] m_q[$];
  int          m_acc = 0;
  int          m_pop = 0;
  bit          m_err = 1'b0;

  function automatic bit m_ready();
    return (m_mode == M_RUN) && (m_q.size() < 2) && (m_acc < MSG);
  endfunction

  function automatic bit m_valid();
    return (m_mode == M_RUN) && (m_q.size() > 0);
  endfunction

  function automatic int m_phase();
    if (!m_valid()) return 3;
    if (m_pop == 0) return 0;
    if (m_pop <= NPT) return 1;
    if (m_pop == NPT + 1) return 2;
    return 3;
  endfunction

  bit u_rdy, u_vld;
  always @(posedge clock) begin
    u_rdy = m_ready();
    u_vld = m_valid();
    if (reset) begin
      m_mode = M_IDLE; m_q.delete(); m_acc = 0; m_pop = 0; m_err = 1'b0;
    end else if (!i_sys_enable) begin
      m_mode = M_IDLE; m_q.delete(); m_acc = 0; m_pop = 0;
    end else if (m_mode == M_IDLE) begin
      if (i_start) begin
        m_mode = M_RUN; m_acc = 0; m_pop = 0; m_err = 1'b0;
      end
      if (i_data_consumed) m_err = 1'b1;
    end else if (m_mode == M_RUN) begin
      if ((i_data_consumed && !u_vld) || i_done) m_err = 1'b1;
      if (i_data_consumed && u_vld) begin
        void'(m_q.pop_front());
        m_pop++;
        if (m_pop == MSG) m_mode = M_WAIT;
      end
      if (i_s_valid && u_rdy) begin
        m_q.push_back(i_s_data);
        m_acc++;
      end
    end else begin
      if (i_data_consumed) m_err = 1'b1;
      if (i_done) m_mode = M_IDLE;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("m_ready", o_s_ready, m_ready());
      chk("m_valid", o_data_valid, m_valid());
      chk("m_phase", o_phase, m_phase());
      chk("m_busy", o_busy, m_mode != M_IDLE);
      chk("m_error", o_error, m_err);
      if (m_valid()) chk("m_data", o_data, m_q[0]);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, o_s_ready, 0);
    chk({tag, "_valid"}, o_data_valid, 0);
    chk({tag, "_phase"}, o_phase, 3);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  task automatic run_msg(input logic [DW-1:0] base);
    int sent, popped;
    bit a, cons;
    logic [1:0] ph_lit [5];
    ph_lit[0] = 2'd0; ph_lit[1] = 2'd1; ph_lit[2] = 2'd1; ph_lit[3] = 2'd1; ph_lit[4] = 2'd2;
    sent = 0; popped = 0;
    i_start = 1'b1; cyc(); i_start = 1'b0;
    chk("nom_busy", o_busy, 1);
    chk("nom_err_clr", o_error, 0);
    for (int c = 0; c < 100 && popped < MSG; c++) begin
      cons = (c % 12 == 11);
      if (cons) begin
        chk("nom_valid", o_data_valid, 1);
        chk("nom_data", o_data, base * DW'(popped + 1));
        chk("nom_phase", o_phase, ph_lit[popped]);
      end
      i_data_consumed = cons;
      i_s_valid = (sent < MSG);
      i_s_data = base * DW'(sent + 1);
      a = i_s_valid && o_s_ready;
      cyc();
      if (a) sent++;
      if (cons) popped++;
    end
    i_data_consumed = 1'b0; i_s_valid = 1'b0;
    chk("nom_pops", popped, MSG);
    chk("wait_busy", o_busy, 1);
    chk("wait_valid", o_data_valid, 0);
    chk("wait_ready", o_s_ready, 0);
    chk("wait_phase", o_phase, 3);
    i_done = 1'b1; cyc(); i_done = 1'b0;
    chk("done_busy", o_busy, 0);
  endtask

  initial begin
    int acc;
    bit a;
    cyc(); cyc();
    chk_on = 1'b1;
    reset = 1'b0;
    chk_reset_outputs("rst");
    chk("rst_err", o_error, 0);
    chk("rst_data", o_data, 0);

    run_msg(64'h1111_1111_1111_1111);

    // Backpressure, then simultaneous push and pop at count 1, then abort.
    i_start = 1'b1; cyc(); i_start = 1'b0;
    i_s_valid = 1'b1; acc = 0;
    for (int i = 0; i < 6; i++) begin
      i_s_data = 64'hB000_0000_0000_0000 | DW'(acc);
      a = o_s_ready;
      cyc();
      if (a) acc++;
    end
    chk("bp_accepted", acc, 2);
    chk("bp_ready", o_s_ready, 0);
    chk("bp_head", o_data, 64'hB000_0000_0000_0000);
    i_data_consumed = 1'b1; cyc(); i_data_consumed = 1'b0;
    chk("bp_ready_back", o_s_ready, 1);
    chk("bp_head2", o_data, 64'hB000_0000_0000_0001);
    a = o_s_ready; cyc(); if (a) acc++;
    chk("bp_third", acc, 3);
    chk("bp_full", o_s_ready, 0);
    i_data_consumed = 1'b1; cyc(); i_data_consumed = 1'b0;
    i_s_data = 64'hB000_0000_0000_0003;
    chk("sim_head_before", o_data, 64'hB000_0000_0000_0002);
    i_data_consumed = 1'b1; cyc(); i_data_consumed = 1'b0; i_s_valid = 1'b0;
    chk("sim_head_after", o_data, 64'hB000_0000_0000_0003);
    chk("sim_valid", o_data_valid, 1);
    chk("sim_ready", o_s_ready, 1);
    chk("sim_phase", o_phase, 1);
    i_sys_enable = 1'b0; cyc(); i_sys_enable = 1'b1;
    chk_reset_outputs("abort");

    // Protocol error: consume on an empty buffer.
    i_start = 1'b1; cyc(); i_start = 1'b0;
    i_data_consumed = 1'b1; cyc(); i_data_consumed = 1'b0;
    chk("err_set", o_error, 1);
    chk("err_phase_empty", o_phase, 3);
    i_s_valid = 1'b1; i_s_data = 64'hC0DE; cyc(); i_s_valid = 1'b0;
    chk("err_pop_unchanged", o_phase, 0);
    chk("err_head", o_data, 64'hC0DE);
    cyc(); cyc();
    chk("err_sticky", o_error, 1);
    i_sys_enable = 1'b0; cyc(); i_sys_enable = 1'b1;
    chk("err_held", o_error, 1);
    run_msg(64'h0101_0101_0101_0101);

    // Reset mid-message with two words buffered.
    i_start = 1'b1; cyc(); i_start = 1'b0;
    i_s_valid = 1'b1; i_s_data = 64'hDEAD; cyc(); i_s_data = 64'hBEEF; cyc(); i_s_valid = 1'b0;
    chk("rst2_valid_pre", o_data_valid, 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk_reset_outputs("rst2");
    chk("rst2_data", o_data, 0);
    i_start = 1'b1; cyc(); i_start = 1'b0;
    chk("rst2_no_stale", o_data_valid, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset           = ($urandom_range(0, 199) == 0);
      i_sys_enable    = ($urandom_range(0, 99) != 0);
      i_start         = ($urandom_range(0, 7) == 0);
      i_s_valid       = ($urandom_range(0, 1) == 1);
      i_s_data        = {$urandom, $urandom};
      i_data_consumed = ($urandom_range(0, 2) == 0);
      i_done          = ($urandom_range(0, 5) == 0);
      cyc();
    end
    reset = 1'b0; i_sys_enable = 1'b1; i_start = 1'b0; i_s_valid = 1'b0;
    i_data_consumed = 1'b0; i_done = 1'b0;
    cyc(); cyc();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_data_sequencer.md
# ascon_data_sequencer

Upstream feeder for the Ascon control FSM. Accepts a five-word message from the host over a valid/ready stream: one associated-data block, three plaintext blocks and one finalization block. It buffers up to two words and presents the head word to the datapath, with a level `o_data_valid` that drives the FSM's `i_data_valid`. Each word is retired on the FSM's data-XOR pulse, and the sequencer tracks the message phase until the FSM reports done.

## Interface
- `DATA_WIDTH`, default 64: width of host and core data words.
- `NUM_PT_BLOCKS`, default 3: plaintext blocks per message. The message length is `NUM_PT_BLOCKS + 2` words.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clock`, input, 1: system clock. All logic is clocked on the rising edge.
- `reset`, input, 1: synchronous reset, active high.
- `i_sys_enable`, input, 1: when low, the block returns to IDLE synchronously and flushes its buffer.
- `i_start`, input, 1: starts a message. Sampled only in IDLE.
- `i_s_data`, input, DATA_WIDTH: host word.
- `i_s_valid`, input, 1: host word valid.
- `o_s_ready`, output, 1: the block can accept a word.
- `o_data`, output, DATA_WIDTH: head word presented to the datapath.
- `o_data_valid`, output, 1: head word valid. Drives the FSM's `i_data_valid`.
- `i_data_consumed`, input, 1: the FSM's data-XOR-begin pulse. Pops the head word.
- `i_done`, input, 1: the FSM's done pulse. Ends the message.
- `o_phase`, output, 2: phase of the head word: 0 = AD, 1 = PT, 2 = FINAL, 3 = none.
- `o_busy`, output, 1: high in any state other than IDLE.
- `o_error`, output, 1: sticky protocol error. Cleared on `i_start` accepted in IDLE, or on reset.

## Operation
- **Reset values:** all outputs are 0, except `o_phase` = 3. State is IDLE, the buffer is empty and both counters are 0.
- **States:** IDLE, RUN, WAIT_DONE.
- **IDLE:**
  - `o_s_ready` = 0 and `o_data_valid` = 0.
  - `i_start` with `i_sys_enable` high moves to RUN. It clears `acc_cnt`, `pop_cnt` and `o_error`.
- **RUN, host side:**
  - `o_s_ready` = (buffer count < 2) && (`acc_cnt` < message length).
  - A push happens on `i_s_valid && o_s_ready`, and increments `acc_cnt` (3 bits).
- **RUN, core side:**
  - `o_data_valid` = (buffer count != 0).
  - `i_data_consumed` while valid pops the head and increments `pop_cnt` (3 bits).
  - When `pop_cnt` reaches the message length, the state moves to WAIT_DONE.
- **Phase decode:** `o_phase` follows `pop_cnt`.
  - `pop_cnt` = 0 gives AD.
  - `pop_cnt` from 1 to `NUM_PT_BLOCKS` gives PT.
  - `pop_cnt` = `NUM_PT_BLOCKS` + 1 gives FINAL.
  - An empty buffer, or IDLE/WAIT_DONE, gives 3.
- **WAIT_DONE:**
  - `o_s_ready` = 0 and `o_data_valid` = 0.
  - `i_done` moves to IDLE.
- **Errors:** the following set `o_error`, and the offending event is ignored:
  - `i_data_consumed` while the buffer is empty.
  - `i_data_consumed` in IDLE or WAIT_DONE.
  - `i_done` in RUN.
- **Simultaneous push and pop:** allowed at count 1; the count stays 1 and the new word becomes head next cycle. At count 2 no push is possible, because `o_s_ready` is 0.
- **`i_sys_enable` low or `reset` mid-message:** next cycle the state is IDLE, the buffer is empty, and counters and outputs are at reset values. `o_error` is held under `i_sys_enable` low and cleared by `reset`.
- **`i_start` outside IDLE:** ignored.

## Timing
- `o_s_ready`, `o_data_valid` and `o_phase` are decoded from registered state and count only. There is no combinational path from `i_s_valid` or `i_data_consumed` to any output.
- **Push latency:** a word pushed at edge k into an empty buffer appears on `o_data` with `o_data_valid` = 1 in cycle k+1.
- **Pop latency:** a pop at edge k shows the next head, or valid = 0, in cycle k+1.
- **Head stability:** `o_data` is stable from valid-high until the consuming edge, covering the FSM's IDLE_x to START_x handoff.
- **State transitions:** the RUN to WAIT_DONE transition happens at the edge of the final pop. The WAIT_DONE to IDLE transition happens at the edge sampling `i_done`, so `o_busy` falls in the following cycle.

## Structure
- `ascon_pkg` holds:
  - a `phase_e` enum (AD, PT, FINAL, NONE);
  - the `sequencer_state_e` enum;
  - the `MSG_WORDS` constant.
- Sub-module `ascon_fifo2`: a 2-entry register FIFO (push, pop, flush, count, head) with no fall-through. The sequencer FSM and counters live in the top module.

## Test plan
- **Nominal:** push 5 words back-to-back, 0x1111…1 to 0x5555…5. Pulse consumed every 12 cycles. Required: `o_phase` sequence AD, PT, PT, PT, FINAL; `o_data` matches each word; WAIT_DONE after the 5th pop; `i_done` leads to IDLE with `o_busy` = 0 one cycle later.
- **Backpressure:** host valid is held high with no consume. Required: exactly 2 words are accepted, then `o_s_ready` = 0. One consume raises ready the next cycle, and the 3rd word is accepted.
- **Simultaneous push and pop at count 1:** required count stays 1, the head changes to the new word next cycle, and `acc_cnt`/`pop_cnt` both increment.
- **Error:** consumed pulse while the buffer is empty in RUN. Required: `o_error` = 1 and sticky, `pop_cnt` unchanged, and `o_error` cleared by the next `i_start` in IDLE.
- **Abort:** drop `i_sys_enable` after 3 pops. Required: the next cycle is IDLE with ready/valid = 0 and `o_phase` = 3. A new `i_start` plus a full message completes normally.
- **Reset:** assert `reset` mid-RUN with 2 words buffered. Required: all outputs are at reset values next cycle, and stale words are never presented.
